// File: rtl/btn_evt.sv
// Button event classifier: turns a debounced, clock-synchronous button level
// into single-cycle press/click/long/repeat/release pulses plus a held level.
module btn_evt #(
  parameter int unsigned LONG_CYC = 25_000_000,
  parameter int unsigned REP_CYC  = 5_000_000,
  parameter int unsigned CNT_W    = 25
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic press_o,
  output logic click_o,
  output logic long_o,
  output logic rep_o,
  output logic rel_o,
  output logic held_o
);

  typedef enum logic [1:0] {IDLE, SHORT, LONG} state_e;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_CYC - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sig_q;
  logic             press_q, press_d;
  logic             click_q, click_d;
  logic             long_q, long_d;
  logic             rep_q, rep_d;
  logic             rel_q, rel_d;
  logic             held_q, held_d;

  // sig_q resets high so a button held through reset yields no press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sig_q   <= 1'b1;
      press_q <= 1'b0;
      click_q <= 1'b0;
      long_q  <= 1'b0;
      rep_q   <= 1'b0;
      rel_q   <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sig_q   <= sig_i;
      press_q <= press_d;
      click_q <= click_d;
      long_q  <= long_d;
      rep_q   <= rep_d;
      rel_q   <= rel_d;
      held_q  <= held_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    click_d = 1'b0;
    long_d  = 1'b0;
    rep_d   = 1'b0;
    rel_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sig_i && !sig_q) begin
          state_d = SHORT;
          cnt_d   = '0;
          press_d = 1'b1;
        end
      end
      SHORT: begin
        // release is tested first so it wins over a coincident terminal count
        if (!sig_i) begin
          state_d = IDLE;
          click_d = 1'b1;
          rel_d   = 1'b1;
        end else if (cnt_q == LONG_LAST) begin
          state_d = LONG;
          cnt_d   = '0;
          long_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      LONG: begin
        if (!sig_i) begin
          state_d = IDLE;
          rel_d   = 1'b1;
        end else if (cnt_q == REP_LAST) begin
          cnt_d = '0;
          rep_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    held_d = (state_d != IDLE);
  end

  assign press_o = press_q;
  assign click_o = click_q;
  assign long_o  = long_q;
  assign rep_o   = rep_q;
  assign rel_o   = rel_q;
  assign held_o  = held_q;

endmodule

// File: tb/tb_btn_evt.sv
// Bench for btn_evt: constant vector table, directed reset/re-press sequences
// and randomized hold patterns against an edge-counting reference model.
module tb_btn_evt;
  localparam int LONG = 8;
  localparam int REP  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sig_i = 1'b0;
  logic press_o, click_o, long_o, rep_o, rel_o, held_o;

  btn_evt #(.LONG_CYC(LONG), .REP_CYC(REP), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .sig_i(sig_i),
    .press_o(press_o), .click_o(click_o), .long_o(long_o),
    .rep_o(rep_o), .rel_o(rel_o), .held_o(held_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       sig;
    logic [5:0] exp;   // {press, click, long, rep, rel, held}
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: m_j counts edges since the press edge of the current press
  logic       m_prev;
  logic       m_active;
  int         m_j;
  logic [5:0] m_exp;

  function automatic logic [5:0] outs();
    return {press_o, click_o, long_o, rep_o, rel_o, held_o};
  endfunction

  task automatic check(input string name, input logic [5:0] got, input logic [5:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s @%0t: got=%b want=%b", name, $time, got, want);
    end
  endtask

  task automatic m_reset();
    m_prev = 1'b1; m_active = 1'b0; m_j = 0; m_exp = '0;
  endtask

  task automatic m_edge(input logic s);
    logic p, c, l, r, rl;
    p = 0; c = 0; l = 0; r = 0; rl = 0;
    if (m_active) begin
      m_j++;
      if (!s) begin
        rl = 1; c = (m_j <= LONG); m_active = 0;
      end else if (m_j == LONG) begin
        l = 1;
      end else if (m_j > LONG && ((m_j - LONG) % REP) == 0) begin
        r = 1;
      end
    end else if (s && !m_prev) begin
      p = 1; m_active = 1; m_j = 0;
    end
    m_prev = s;
    m_exp = {p, c, l, r, rl, m_active};
  endtask

  // Drive now (never at a rising edge), sample 1 time unit after the edge
  task automatic step(input logic s, input logic use_tab, input logic [5:0] tab);
    sig_i = s;
    @(posedge clk);
    m_edge(s);
    #1;
    if (use_tab) check("vec", outs(), tab);
    else         check("model", outs(), m_exp);
  endtask

  task automatic run(input logic s, input int n);
    for (int i = 0; i < n; i++) step(s, 1'b0, '0);
  endtask

  task automatic do_reset(input logic s);
    #1;
    rst_n = 1'b0;
    sig_i = s;
    #1;
    check("rst_async", outs(), 6'b000000);
    repeat (2) @(negedge clk);
    m_reset();
    rst_n = 1'b1;
  endtask

  task automatic add(input logic s, input int n, input logic [5:0] e);
    for (int i = 0; i < n; i++) vecs.push_back('{sig: s, exp: e});
  endtask

  initial begin
    // short press, then hold of exactly LONG, then LONG+1
    add(1'b0, 1, 6'b000000);
    add(1'b1, 1, 6'b100001); add(1'b1, 3, 6'b000001);
    add(1'b0, 1, 6'b010010); add(1'b0, 1, 6'b000000);
    add(1'b1, 1, 6'b100001); add(1'b1, 7, 6'b000001);
    add(1'b0, 1, 6'b010010); add(1'b0, 1, 6'b000000);
    add(1'b1, 1, 6'b100001); add(1'b1, 7, 6'b000001);
    add(1'b1, 1, 6'b001001); add(1'b0, 1, 6'b000010);
    add(1'b0, 1, 6'b000000);

    m_reset();
    do_reset(1'b0);
    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) step(vecs[i].sig, 1'b1, vecs[i].exp);

    // long hold with repeats and a release from LONG
    run(1'b1, 20); run(1'b0, 2);

    // held through reset: silent until a low sample, then a fresh press
    do_reset(1'b1);
    run(1'b1, 5);
    step(1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 6'b000000);
    step(1'b1, 1'b1, 6'b100001);

    // reset while in LONG, button still held afterwards
    run(1'b1, 12);
    do_reset(1'b1);
    run(1'b1, 6);
    run(1'b0, 1);

    // re-press right after release; long must come 8 edges after the new press
    run(1'b1, 4);
    step(1'b0, 1'b1, 6'b010010);
    step(1'b1, 1'b1, 6'b100001);
    run(1'b1, 7);
    step(1'b1, 1'b1, 6'b001001);
    run(1'b0, 2);

    // randomized hold/release runs with occasional resets
    begin
      logic lvl;
      lvl = 1'b0;
      for (int n = 0; n < 250; n++) begin
        lvl = ~lvl;
        if ($urandom_range(0, 30) == 0) do_reset(logic'($urandom_range(0, 1)));
        run(lvl, int'($urandom_range(1, 18)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    bad++;
    $display("FAIL timeout: got=running want=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule
